// File: rtl/pipeline_decode_stage.sv
// -----------------------------------------------------------------------------
// pipeline_decode_stage
//
// RV32 decode stage with an integrated register file. It sits between fetch and
// execute. It extracts the opcode, funct3/funct7 and register indices, builds the
// sign-extended immediate, and reads both operands with write-back bypass. It
// stalls fetch on a load-use hazard and presents the decoded instruction through
// a registered valid/ready output stage. A flush kills both the held and the
// incoming instruction.
//
// Parameters
//   XLEN      datapath / immediate width (32 or 64)
//   NUM_REGS  architectural registers (32 = RV32I, 16 = RV32E); x0 reads zero
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   valid_i, instruction_i, pc_i incoming instruction from fetch
//   ready_o                      stage accepts the incoming instruction
//   flush_i                      branch redirect: kill in-flight and incoming
//   wb_reg_write_i, wb_write_reg_i, wb_write_data_i   write-back port
//   ex_mem_read_i, ex_rd_i       load currently in EX and its destination
//   valid_o, ready_i             output handshake towards execute
//   opcode_o, funct3_o, funct7_o, rs1_o, rs2_o, rd_o  decoded fields
//   read_data1_o, read_data2_o   operand values
//   imm_o                        sign-extended immediate
//   pc_o                         PC of the decoded instruction
//   illegal_o                    unsupported opcode or out-of-range register
// -----------------------------------------------------------------------------
module pipeline_decode_stage #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [31:0]     instruction_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            ready_o,
  input  logic            flush_i,
  input  logic            wb_reg_write_i,
  input  logic [4:0]      wb_write_reg_i,
  input  logic [XLEN-1:0] wb_write_data_i,
  input  logic            ex_mem_read_i,
  input  logic [4:0]      ex_rd_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [6:0]      opcode_o,
  output logic [2:0]      funct3_o,
  output logic [6:0]      funct7_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] read_data1_o,
  output logic [XLEN-1:0] read_data2_o,
  output logic [XLEN-1:0] imm_o,
  output logic [XLEN-1:0] pc_o,
  output logic            illegal_o
);

  localparam int IDX_W = $clog2(NUM_REGS);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Indices at or above NUM_REGS do not exist (RV32E uses only x0..x15).
  function automatic logic in_range(input logic [4:0] idx);
    return int'(idx) < NUM_REGS;
  endfunction

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] r_regs [NUM_REGS];

  // NOTE: this array is reset because every entry must read 0 after reset.
  // That turns it into flops rather than a RAM macro, which is acceptable at
  // this size. Sequential state is always assigned with <= so that all flops
  // update together at the clock edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (wb_reg_write_i && wb_write_reg_i != 5'd0 && in_range(wb_write_reg_i)) begin
      r_regs[wb_write_reg_i[IDX_W-1:0]] <= wb_write_data_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Field extraction and immediate / usage decode
  // ---------------------------------------------------------------------------
  logic [6:0]        w_opcode;
  logic [4:0]        w_rs1, w_rs2, w_rd;
  logic signed [31:0] w_imm32;
  logic              w_legal_op, w_use_rs1, w_use_rs2, w_use_rd;
  logic              w_illegal;
  logic [XLEN-1:0]   w_imm;

  assign w_opcode = instruction_i[6:0];
  assign w_rs1    = instruction_i[19:15];
  assign w_rs2    = instruction_i[24:20];
  assign w_rd     = instruction_i[11:7];

  // NOTE: every output of this block gets a default first, so no path through
  // the case leaves a variable unassigned and no latch is inferred.
  always_comb begin
    w_imm32    = '0;
    w_legal_op = 1'b1;
    w_use_rs1  = 1'b1;
    w_use_rs2  = 1'b0;
    w_use_rd   = 1'b1;
    case (w_opcode)
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:
        w_imm32 = {{20{instruction_i[31]}}, instruction_i[31:20]};
      OP_STORE: begin
        w_imm32   = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
        w_use_rs2 = 1'b1;
        w_use_rd  = 1'b0;
      end
      OP_BRANCH: begin
        w_imm32   = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                     instruction_i[30:25], instruction_i[11:8], 1'b0};
        w_use_rs2 = 1'b1;
        w_use_rd  = 1'b0;
      end
      OP_LUI, OP_AUIPC: begin
        w_imm32   = {instruction_i[31:12], 12'b0};
        w_use_rs1 = 1'b0;
      end
      OP_JAL: begin
        w_imm32   = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                     instruction_i[20], instruction_i[30:21], 1'b0};
        w_use_rs1 = 1'b0;
      end
      OP_REG:   w_use_rs2 = 1'b1;
      OP_FENCE: ;
      default:  w_legal_op = 1'b0;
    endcase
  end

  // The size cast of a signed operand sign-extends to XLEN.
  assign w_imm = XLEN'(w_imm32);

  assign w_illegal = !w_legal_op
                   || (w_use_rs1 && !in_range(w_rs1))
                   || (w_use_rs2 && !in_range(w_rs2))
                   || (w_use_rd  && !in_range(w_rd));

  // ---------------------------------------------------------------------------
  // Operand read with write-back bypass
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] w_read_data1, w_read_data2;

  always_comb begin
    w_read_data1 = '0;
    if (w_rs1 != 5'd0 && in_range(w_rs1)) begin
      if (wb_reg_write_i && wb_write_reg_i == w_rs1) w_read_data1 = wb_write_data_i;
      else                                           w_read_data1 = r_regs[w_rs1[IDX_W-1:0]];
    end
  end

  always_comb begin
    w_read_data2 = '0;
    if (w_rs2 != 5'd0 && in_range(w_rs2)) begin
      if (wb_reg_write_i && wb_write_reg_i == w_rs2) w_read_data2 = wb_write_data_i;
      else                                           w_read_data2 = r_regs[w_rs2[IDX_W-1:0]];
    end
  end

  // ---------------------------------------------------------------------------
  // Hazard detection and handshake
  // ---------------------------------------------------------------------------
  logic w_hazard, w_load_en, w_accept;
  logic r_valid;

  // Only sources the instruction actually reads can cause a load-use stall.
  assign w_hazard = valid_i && ex_mem_read_i && ex_rd_i != 5'd0
                 && ((w_use_rs1 && ex_rd_i == w_rs1) || (w_use_rs2 && ex_rd_i == w_rs2));

  assign w_load_en = ready_i || !r_valid;
  // During a flush the incoming instruction is dropped, so a hazard must not
  // hold it. Fetch sees ready and moves on.
  assign ready_o   = w_load_en && (!w_hazard || flush_i) && !rst_i;
  assign w_accept  = valid_i && ready_o && !flush_i;

  // ---------------------------------------------------------------------------
  // Output pipeline register
  // ---------------------------------------------------------------------------
  logic [6:0]      r_opcode, r_funct7;
  logic [2:0]      r_funct3;
  logic [4:0]      r_rs1, r_rs2, r_rd;
  logic [XLEN-1:0] r_read_data1, r_read_data2, r_imm, r_pc;
  logic            r_illegal;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid      <= 1'b0;
      r_opcode     <= '0;
      r_funct3     <= '0;
      r_funct7     <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_read_data1 <= '0;
      r_read_data2 <= '0;
      r_imm        <= '0;
      r_pc         <= '0;
      r_illegal    <= 1'b0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_load_en) begin
      if (w_accept) begin
        r_valid      <= 1'b1;
        r_opcode     <= w_opcode;
        r_funct3     <= instruction_i[14:12];
        r_funct7     <= instruction_i[31:25];
        r_rs1        <= w_rs1;
        r_rs2        <= w_rs2;
        r_rd         <= w_rd;
        r_read_data1 <= w_read_data1;
        r_read_data2 <= w_read_data2;
        r_imm        <= w_imm;
        r_pc         <= pc_i;
        r_illegal    <= w_illegal;
      end else begin
        // Bubble: the payload fields keep their last value.
        r_valid <= 1'b0;
      end
    end else begin
      // Held by backpressure. Track write-backs so the operands never go stale.
      if (wb_reg_write_i && wb_write_reg_i != 5'd0 && in_range(wb_write_reg_i)) begin
        if (wb_write_reg_i == r_rs1) r_read_data1 <= wb_write_data_i;
        if (wb_write_reg_i == r_rs2) r_read_data2 <= wb_write_data_i;
      end
    end
  end

  assign valid_o      = r_valid;
  assign opcode_o     = r_opcode;
  assign funct3_o     = r_funct3;
  assign funct7_o     = r_funct7;
  assign rs1_o        = r_rs1;
  assign rs2_o        = r_rs2;
  assign rd_o         = r_rd;
  assign read_data1_o = r_read_data1;
  assign read_data2_o = r_read_data2;
  assign imm_o        = r_imm;
  assign pc_o         = r_pc;
  assign illegal_o    = r_illegal;

endmodule

// File: tb/tb_pipeline_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_pipeline_decode_stage
//
// Directed bench for pipeline_decode_stage. It uses an RV32I instance and an
// RV32E (NUM_REGS=16) instance that share all inputs. A vector table covers the
// decode of the base formats. Hand-written sequences cover bypass, x0, load-use,
// backpressure, flush, RV32E range checks and reset mid-stream.
// -----------------------------------------------------------------------------
module tb_pipeline_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        ex_mr;
  logic [4:0]  ex_rd;
  logic        ready_i;

  logic        ready_o, valid_o, illegal_o;
  logic [6:0]  opcode_o, funct7_o;
  logic [2:0]  funct3_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [31:0] rd1_o, rd2_o, imm_o, pc_o;

  logic        e_ready_o, e_valid_o, e_illegal_o;
  logic [6:0]  e_opcode_o, e_funct7_o;
  logic [2:0]  e_funct3_o;
  logic [4:0]  e_rs1_o, e_rs2_o, e_rd_o;
  logic [31:0] e_rd1_o, e_rd2_o, e_imm_o, e_pc_o;

  int total = 0;
  int bad   = 0;
  int emit_cnt = 0;

  always #5 clk = ~clk;

  pipeline_decode_stage #(.XLEN(32), .NUM_REGS(32)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .instruction_i(instr), .pc_i(pc),
    .ready_o(ready_o), .flush_i(flush), .wb_reg_write_i(wb_we), .wb_write_reg_i(wb_reg),
    .wb_write_data_i(wb_data), .ex_mem_read_i(ex_mr), .ex_rd_i(ex_rd), .valid_o(valid_o),
    .ready_i(ready_i), .opcode_o(opcode_o), .funct3_o(funct3_o), .funct7_o(funct7_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .read_data1_o(rd1_o), .read_data2_o(rd2_o),
    .imm_o(imm_o), .pc_o(pc_o), .illegal_o(illegal_o)
  );

  pipeline_decode_stage #(.XLEN(32), .NUM_REGS(16)) dut_e (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .instruction_i(instr), .pc_i(pc),
    .ready_o(e_ready_o), .flush_i(flush), .wb_reg_write_i(wb_we), .wb_write_reg_i(wb_reg),
    .wb_write_data_i(wb_data), .ex_mem_read_i(ex_mr), .ex_rd_i(ex_rd), .valid_o(e_valid_o),
    .ready_i(ready_i), .opcode_o(e_opcode_o), .funct3_o(e_funct3_o), .funct7_o(e_funct7_o),
    .rs1_o(e_rs1_o), .rs2_o(e_rs2_o), .rd_o(e_rd_o), .read_data1_o(e_rd1_o),
    .read_data2_o(e_rd2_o), .imm_o(e_imm_o), .pc_o(e_pc_o), .illegal_o(e_illegal_o)
  );

  // Count instructions handed to execute (valid & ready at a clock edge).
  always @(posedge clk) if (valid_o && ready_i) emit_cnt++;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        ill;
    logic        chk_data;
    logic [31:0] d1;
    logic [31:0] d2;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_i = 1'b0; instr = '0; pc = '0; flush = 1'b0;
    wb_we = 1'b0; wb_reg = '0; wb_data = '0; ex_mr = 1'b0; ex_rd = '0; ready_i = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // The register file is preloaded with x_i = 0x1000 + i.
    vecs[0] = '{32'hFE000EE3, 32'h100, 7'h63, 3'd0, 7'h7F, 5'd0,  5'd0,  5'd29, 32'hFFFFFFFC, 1'b0, 1'b1, 32'h0,    32'h0};
    vecs[1] = '{32'h0080006F, 32'h104, 7'h6F, 3'd0, 7'h00, 5'd0,  5'd8,  5'd0,  32'h00000008, 1'b0, 1'b0, 32'h0,    32'h0};
    vecs[2] = '{32'hFE112E23, 32'h108, 7'h23, 3'd2, 7'h7F, 5'd2,  5'd1,  5'd28, 32'hFFFFFFFC, 1'b0, 1'b1, 32'h1002, 32'h1001};
    vecs[3] = '{32'h12345037, 32'h10C, 7'h37, 3'd5, 7'h09, 5'd8,  5'd3,  5'd0,  32'h12345000, 1'b0, 1'b0, 32'h0,    32'h0};
    vecs[4] = '{32'hFFF00093, 32'h110, 7'h13, 3'd0, 7'h7F, 5'd0,  5'd31, 5'd1,  32'hFFFFFFFF, 1'b0, 1'b0, 32'h0,    32'h0};
    vecs[5] = '{32'h00218233, 32'h114, 7'h33, 3'd0, 7'h00, 5'd3,  5'd2,  5'd4,  32'h00000000, 1'b0, 1'b1, 32'h1003, 32'h1002};
    vecs[6] = '{32'hFFFFF297, 32'h118, 7'h17, 3'd7, 7'h7F, 5'd31, 5'd31, 5'd5,  32'hFFFFF000, 1'b0, 1'b0, 32'h0,    32'h0};
    vecs[7] = '{32'h0000007F, 32'h11C, 7'h7F, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b1, 1'b1, 32'h0,    32'h0};

    idle_inputs();
    rst = 1'b1;
    tick();
    #1 check("reset_ready_o", ready_o, 1'b0);
    tick();
    check("reset_valid_o", valid_o, 1'b0);
    check("reset_imm_o", imm_o, 32'h0);
    check("reset_pc_o", pc_o, 32'h0);
    check("reset_illegal_o", illegal_o, 1'b0);
    check("reset_read_data1_o", rd1_o, 32'h0);
    rst = 1'b0;

    // Preload the register file through the write-back port.
    for (int i = 1; i < 32; i++) begin
      wb_we = 1'b1; wb_reg = 5'(i); wb_data = 32'h1000 + 32'(i);
      tick();
    end
    wb_we = 1'b0;

    // Decode table.
    for (int v = 0; v < 8; v++) begin
      valid_i = 1'b1; instr = vecs[v].instr; pc = vecs[v].pc;
      tick();
      check($sformatf("v%0d_valid_o", v), valid_o, 1'b1);
      check($sformatf("v%0d_opcode_o", v), opcode_o, vecs[v].op);
      check($sformatf("v%0d_funct3_o", v), funct3_o, vecs[v].f3);
      check($sformatf("v%0d_funct7_o", v), funct7_o, vecs[v].f7);
      check($sformatf("v%0d_rs1_o", v), rs1_o, vecs[v].rs1);
      check($sformatf("v%0d_rs2_o", v), rs2_o, vecs[v].rs2);
      check($sformatf("v%0d_rd_o", v), rd_o, vecs[v].rd);
      check($sformatf("v%0d_imm_o", v), imm_o, vecs[v].imm);
      check($sformatf("v%0d_pc_o", v), pc_o, vecs[v].pc);
      check($sformatf("v%0d_illegal_o", v), illegal_o, vecs[v].ill);
      check($sformatf("v%0d_e_illegal_o", v), e_illegal_o, vecs[v].ill);
      if (vecs[v].chk_data) begin
        check($sformatf("v%0d_read_data1_o", v), rd1_o, vecs[v].d1);
        check($sformatf("v%0d_read_data2_o", v), rd2_o, vecs[v].d2);
      end
    end

    // Bypass: write x5 while decoding ADD x1,x5,x0. Next cycle it is in the array.
    instr = 32'h000280B3; pc = 32'h200;
    wb_we = 1'b1; wb_reg = 5'd5; wb_data = 32'hDEADBEEF;
    tick();
    check("bypass_read_data1_o", rd1_o, 32'hDEADBEEF);
    check("bypass_read_data2_o", rd2_o, 32'h0);
    wb_we = 1'b0;
    tick();
    check("array_read_data1_o", rd1_o, 32'hDEADBEEF);

    // x0: a write of 7 is neither bypassed nor stored.
    instr = 32'h000000B3;
    wb_we = 1'b1; wb_reg = 5'd0; wb_data = 32'h7;
    tick();
    check("x0_bypass_read_data1_o", rd1_o, 32'h0);
    wb_we = 1'b0;
    tick();
    check("x0_array_read_data1_o", rd1_o, 32'h0);

    // Load-use: LW x3 in EX while ADD x4,x3,x2 is presented.
    instr = 32'h00218233; pc = 32'h300;
    ex_mr = 1'b1; ex_rd = 5'd3;
    #1 check("hazard_ready_o", ready_o, 1'b0);
    tick();
    check("hazard_bubble_valid_o", valid_o, 1'b0);
    ex_mr = 1'b0;
    wb_we = 1'b1; wb_reg = 5'd3; wb_data = 32'hCAFE0003;
    #1 check("after_hazard_ready_o", ready_o, 1'b1);
    tick();
    wb_we = 1'b0;
    check("after_hazard_valid_o", valid_o, 1'b1);
    check("after_hazard_rd_o", rd_o, 5'd4);
    check("after_hazard_read_data1_o", rd1_o, 32'hCAFE0003);
    check("after_hazard_read_data2_o", rd2_o, 32'h1002);
    check("after_hazard_pc_o", pc_o, 32'h300);

    // A match on a field the instruction does not read must not stall (LUI rs1 field = 8).
    instr = 32'h12345037; pc = 32'h304; ex_mr = 1'b1; ex_rd = 5'd8;
    #1 check("unused_src_ready_o", ready_o, 1'b1);
    tick();
    check("unused_src_valid_o", valid_o, 1'b1);

    // Hazard on rs2 of SW x1,-4(x2). The load then leaves and SW is accepted.
    instr = 32'hFE112E23; pc = 32'h310; ex_rd = 5'd1;
    #1 check("rs2_hazard_ready_o", ready_o, 1'b0);
    ex_mr = 1'b0;
    tick();
    check("rs2_hazard_accept_pc_o", pc_o, 32'h310);

    // Backpressure for 3 cycles. WB writes x1 (the held rs2) in the second cycle.
    ready_i = 1'b0; instr = 32'hFFF00093; pc = 32'h314;
    emit_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      wb_we = (k == 1); wb_reg = 5'd1; wb_data = 32'hAAAA0001;
      #1 check($sformatf("hold%0d_ready_o", k), ready_o, 1'b0);
      tick();
      check($sformatf("hold%0d_valid_o", k), valid_o, 1'b1);
      check($sformatf("hold%0d_imm_o", k), imm_o, 32'hFFFFFFFC);
      check($sformatf("hold%0d_pc_o", k), pc_o, 32'h310);
      check($sformatf("hold%0d_read_data1_o", k), rd1_o, 32'h1002);
      check($sformatf("hold%0d_read_data2_o", k), rd2_o, (k >= 1) ? 32'hAAAA0001 : 32'h1001);
    end
    wb_we = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    tick();
    check("release_valid_o", valid_o, 1'b0);
    tick();
    check("release_emit_count", emit_cnt, 1);

    // Flush while a held instruction is stalled. The incoming LUI must not be captured.
    valid_i = 1'b1; instr = 32'h00218233; pc = 32'h400;
    tick();
    check("pre_flush_valid_o", valid_o, 1'b1);
    ready_i = 1'b0; flush = 1'b1; instr = 32'h12345037; pc = 32'h404;
    #1 check("flush_held_ready_o", ready_o, 1'b0);
    tick();
    check("flush_valid_o", valid_o, 1'b0);
    flush = 1'b0; ready_i = 1'b1; valid_i = 1'b0;
    tick();
    check("post_flush_valid_o", valid_o, 1'b0);
    check("post_flush_pc_o", pc_o, 32'h400);

    // Flush beats hazard: ready_o rises so fetch discards, and no output appears.
    valid_i = 1'b1; instr = 32'h00218233; pc = 32'h408; ex_mr = 1'b1; ex_rd = 5'd3; flush = 1'b1;
    #1 check("flush_hazard_ready_o", ready_o, 1'b1);
    tick();
    check("flush_hazard_valid_o", valid_o, 1'b0);
    flush = 1'b0; ex_mr = 1'b0; ex_rd = 5'd0;

    // ADD x1,x17,x2: legal on RV32I, illegal on RV32E with x17 reading 0.
    instr = 32'h002880B3; pc = 32'h500;
    tick();
    check("rv32e_valid_o", e_valid_o, 1'b1);
    check("rv32e_illegal_o", e_illegal_o, 1'b1);
    check("rv32e_rs1_o", e_rs1_o, 5'd17);
    check("rv32e_read_data1_o", e_rd1_o, 32'h0);
    check("rv32e_read_data2_o", e_rd2_o, 32'h1002);
    check("rv32i_illegal_o", illegal_o, 1'b0);
    check("rv32i_read_data1_o", rd1_o, 32'h1011);

    // Reset while an instruction is held: it is dropped and everything clears.
    ready_i = 1'b0; valid_i = 1'b1; rst = 1'b1;
    #1 check("midrst_ready_o", ready_o, 1'b0);
    tick();
    check("midrst_valid_o", valid_o, 1'b0);
    check("midrst_opcode_o", opcode_o, 7'h0);
    check("midrst_rs1_o", rs1_o, 5'd0);
    check("midrst_read_data1_o", rd1_o, 32'h0);
    check("midrst_pc_o", pc_o, 32'h0);
    check("midrst_e_valid_o", e_valid_o, 1'b0);
    check("midrst_e_illegal_o", e_illegal_o, 1'b0);
    check("midrst_e_read_data2_o", e_rd2_o, 32'h0);
    rst = 1'b0; ready_i = 1'b1;
    instr = 32'h000280B3; pc = 32'h600;
    tick();
    check("post_rst_valid_o", valid_o, 1'b1);
    check("post_rst_regfile_cleared", rd1_o, 32'h0);

    idle_inputs();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
